// File: rtl/piso_pkg.sv
// piso_pkg
//   Shared types and helpers for the parallel-in/serial-out transmitter.
//   piso_state_t : FSM state encoding (IDLE, SHIFT)
//   ctr_width()  : bit-counter width for a given word width
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  function automatic int ctr_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if
//   Load handshake plus serial output bundle of the PISO transmitter.
//   load_valid / load_ready / load_data : word load handshake
//   sout / sout_valid / sout_last       : serial bit stream with framing
//   busy                                : a frame is in progress
//   Modports: master = word source / stream sink, slave = the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy
  );

endinterface

// File: rtl/piso_bit_counter.sv
// piso_bit_counter
//   Position counter for the bit currently on the serial line.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : reload to 0 (new word accepted or frame finished)
//   inc          : advance to the next bit position
//   is_last      : counter sits on the final bit (WIDTH-1)
//   next_is_last : counter sits on the bit before the final one (WIDTH-2)
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic is_last,
  output logic next_is_last
);

  localparam int CW = ctr_width(WIDTH);

  logic [CW-1:0] cnt;

  // Wrap is never used: clr is always asserted before cnt could pass WIDTH-1.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign is_last      = (cnt == CW'(WIDTH - 1));
  assign next_is_last = (cnt == CW'(WIDTH - 2));

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in, serial-out transmitter. A WIDTH-bit word accepted over the
//   load handshake is shifted out one bit per clk with a per-bit valid strobe
//   and a last-bit marker. Back-to-back words are accepted during the last
//   bit, giving a gapless stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : piso_serializer_if slave (load handshake, serial outputs, busy)
//   WIDTH    : word width, 2..32
//   LSB_FIRST: 1 = bit 0 first, 0 = bit WIDTH-1 first
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | line quiet, ready for a word, all outputs 0
//   SHIFT | frame on the line, sout carries one bit/cycle
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  piso_serializer_if.slave    bus
);

  piso_state_t      state;
  logic [WIDTH-1:0] sr;         // bits still waiting to go out after sout

  logic             accept;
  logic             frame_end;
  logic             is_last;
  logic             next_is_last;

  logic             first_bit;
  logic [WIDTH-1:0] load_rem;
  logic             next_bit;
  logic [WIDTH-1:0] shift_rem;

  // Ready during the last bit so the next word follows with no bubble.
  assign bus.load_ready = (state == IDLE) || bus.sout_last;
  assign accept         = bus.load_valid && bus.load_ready;
  assign frame_end      = (state == SHIFT) && is_last;

  // The shift register always holds the not-yet-sent bits aligned so the
  // next one to send sits at the outgoing end.
  always_comb begin
    first_bit = 1'b0;
    next_bit  = 1'b0;
    load_rem  = '0;
    shift_rem = '0;
    if (LSB_FIRST) begin
      first_bit = bus.load_data[0];
      load_rem  = bus.load_data >> 1;
      next_bit  = sr[0];
      shift_rem = sr >> 1;
    end else begin
      first_bit = bus.load_data[WIDTH-1];
      load_rem  = bus.load_data << 1;
      next_bit  = sr[WIDTH-1];
      shift_rem = sr << 1;
    end
  end

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk          (clk),
    .rst          (rst),
    .clr          (accept || frame_end),
    .inc          ((state == SHIFT) && !is_last),
    .is_last      (is_last),
    .next_is_last (next_is_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sr             <= '0;
      bus.sout       <= 1'b0;
      bus.sout_valid <= 1'b0;
      bus.sout_last  <= 1'b0;
      bus.busy       <= 1'b0;
    end else if (accept) begin
      state          <= SHIFT;
      sr             <= load_rem;
      bus.sout       <= first_bit;
      bus.sout_valid <= 1'b1;
      bus.sout_last  <= 1'b0;     // WIDTH >= 2, so the first bit is never last
      bus.busy       <= 1'b1;
    end else if (state == SHIFT) begin
      if (frame_end) begin
        state          <= IDLE;
        sr             <= '0;
        bus.sout       <= 1'b0;
        bus.sout_valid <= 1'b0;
        bus.sout_last  <= 1'b0;
        bus.busy       <= 1'b0;
      end else begin
        sr             <= shift_rem;
        bus.sout       <= next_bit;
        bus.sout_valid <= 1'b1;
        bus.sout_last  <= next_is_last;
        bus.busy       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  localparam int W = 4;

  logic clk;
  logic rst;

  piso_serializer_if #(.WIDTH(W)) if0 ();
  piso_serializer_if #(.WIDTH(W)) if1 ();

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of bits still to appear on the line, front = the
  // bit on the line now. Each edge retires the front bit; an accepted word
  // appends its WIDTH bits in transmit order, the final one flagged last.
  typedef struct {
    logic b;
    logic last;
  } mbit_t;

  mbit_t q0[$];
  mbit_t q1[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] s0, s1;   // captured streams, oldest bit in the MSB
  int          n0, n1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic clear_streams();
    s0 = '0; s1 = '0; n0 = 0; n1 = 0;
  endtask

  task automatic check_outputs();
    logic eb, ev, el, er;
    ev = (q0.size() > 0);
    eb = ev ? q0[0].b : 1'b0;
    el = ev ? q0[0].last : 1'b0;
    er = !ev || q0[0].last;
    check("lsb_sout",  32'(if0.sout),       32'(eb));
    check("lsb_valid", 32'(if0.sout_valid), 32'(ev));
    check("lsb_last",  32'(if0.sout_last),  32'(el));
    check("lsb_busy",  32'(if0.busy),       32'(ev));
    check("lsb_ready", 32'(if0.load_ready), 32'(er));
    ev = (q1.size() > 0);
    eb = ev ? q1[0].b : 1'b0;
    el = ev ? q1[0].last : 1'b0;
    er = !ev || q1[0].last;
    check("msb_sout",  32'(if1.sout),       32'(eb));
    check("msb_valid", 32'(if1.sout_valid), 32'(ev));
    check("msb_last",  32'(if1.sout_last),  32'(el));
    check("msb_busy",  32'(if1.busy),       32'(ev));
    check("msb_ready", 32'(if1.load_ready), 32'(er));
    if (if0.sout_valid) begin s0 = {s0[30:0], if0.sout}; n0++; end
    if (if1.sout_valid) begin s1 = {s1[30:0], if1.sout}; n1++; end
  endtask

  // One clock: apply inputs, advance the model across the edge, then check.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d);
    logic acc0, acc1;
    rst = r;
    if0.load_valid = v; if0.load_data = d;
    if1.load_valid = v; if1.load_data = d;
    acc0 = v && !r && ((q0.size() == 0) || q0[0].last);
    acc1 = v && !r && ((q1.size() == 0) || q1[0].last);
    @(posedge clk);
    if (r) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (acc0) for (int i = 0; i < W; i++) q0.push_back('{b: d[i], last: (i == W-1)});
      if (acc1) for (int i = 0; i < W; i++) q1.push_back('{b: d[W-1-i], last: (i == W-1)});
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    rst = 1'b1;
    if0.load_valid = 1'b0; if0.load_data = '0;
    if1.load_valid = 1'b0; if1.load_data = '0;
    clear_streams();

    // Reset and idle values
    cycle(1, 0, 4'h0);
    cycle(1, 1, 4'hF);           // reset overrides a concurrent load
    for (int i = 0; i < 5; i++) cycle(0, 0, 4'h0);

    // Single word
    clear_streams();
    cycle(0, 1, 4'b1101);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0);
    check("single_lsb", s0, 32'b1011);
    check("single_msb", s1, 32'b1101);
    check("single_len", 32'(n0), 32'd4);

    // Back-to-back, second word presented during sout_last
    clear_streams();
    cycle(0, 1, 4'b1101);
    for (int i = 0; i < 3; i++) cycle(0, 0, 4'h0);
    cycle(0, 1, 4'b0010);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0);
    check("b2b_lsb", s0, 32'b10110100);
    check("b2b_msb", s1, 32'b11010010);
    check("b2b_len", 32'(n0), 32'd8);

    // Hold-off: load_valid mid-frame is ignored until the last bit
    clear_streams();
    cycle(0, 1, 4'b1101);
    cycle(0, 1, 4'b0110);
    cycle(0, 1, 4'b0110);
    cycle(0, 0, 4'h0);
    cycle(0, 1, 4'b0110);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0);
    check("hold_lsb", s0, 32'b10110110);
    check("hold_msb", s1, 32'b11010110);

    // Reset mid-frame, then a fresh word
    clear_streams();
    cycle(0, 1, 4'b1101);
    cycle(0, 0, 4'h0);
    cycle(1, 0, 4'h0);
    cycle(0, 0, 4'h0);
    cycle(0, 0, 4'h0);
    cycle(0, 1, 4'b0011);
    for (int i = 0; i < 4; i++) cycle(0, 0, 4'h0);
    check("rst_lsb", s0, 32'b101100);
    check("rst_msb", s1, 32'b110011);

    // Randomized traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 60) ? 1'b1 : 1'b0,
            W'($urandom));
    end
    for (int i = 0; i < 6; i++) cycle(0, 0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter; the counterpart to the team's serial-in/serial-out shift register.
- Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per clk.
- Emits a per-bit valid strobe and a last-bit marker.
- Sits at the transmit end of the serial link and feeds the SISO/SIPO receive chain.

Parameters:
- WIDTH, 4, word width in bits; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 is sent first; 0 = bit WIDTH-1 is sent first.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- load_valid  input  1  load_data is presented.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word to serialize.
- sout  output  1  serial data bit (registered).
- sout_valid  output  1  sout carries a frame bit.
- sout_last  output  1  sout carries the final bit of the current word.
- busy  output  1  a frame is in progress.

Behaviour:
- Reset (rst=1 at posedge) sets: state IDLE, shift register 0, bit counter 0, sout=0, sout_valid=0, sout_last=0, busy=0.
- Reset overrides every other input, including a concurrent load.
- FSM states:
  - IDLE: load_ready=1, sout_valid=0, sout=0.
  - SHIFT: a frame is on the line.
- Accept condition: load_valid && load_ready at a posedge.
- On accept, the word is captured.
  - The first bit (bit 0, or bit WIDTH-1 if LSB_FIRST=0) appears on sout after that same edge.
  - sout_valid=1, busy=1, counter=0, state goes to SHIFT.
  - Latency is 1 edge from accept to first bit.
- In SHIFT, each posedge advances to the next bit and increments the counter.
  - The frame is exactly WIDTH consecutive sout_valid cycles, with no bubbles.
- sout_last=1 exactly during the cycle in which counter==WIDTH-1.
- load_ready = (state==IDLE) || sout_last. This allows back-to-back words with zero gap.
- Accept during the sout_last cycle:
  - The new word's first bit follows immediately at the next edge.
  - State stays in SHIFT and the counter reloads to 0.
- End of the sout_last cycle with no accept:
  - The next edge returns to IDLE.
  - sout, sout_valid, sout_last and busy all go to 0.
- load_valid while load_ready=0 (mid-frame) is ignored. load_data is not sampled and the frame continues unchanged.
- load_data changing while not accepted has no effect.
- Reset mid-frame:
  - The frame is dropped at that edge; remaining bits are never sent.
  - All outputs reach their reset values after that edge.
  - The next accept after reset starts a fresh frame.
- Counter width is $clog2(WIDTH). Counter wrap is never relied on; it is reloaded explicitly.
- busy equals (state==SHIFT).

Decomposition:
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t
  - function ctr_width(int w) returning $clog2(w)
- Sub-module piso_bit_counter handles load, increment and is_last compare, parameterized by WIDTH. The top level holds the FSM, the shift register and the handshake.

Test Plan:
- WIDTH=4, LSB_FIRST=1: accept 4'b1101 after reset release.
  - Expect sout=1,0,1,1 on 4 consecutive cycles with sout_valid=1.
  - Expect sout_last on the 4th cycle, then IDLE with sout=0 and sout_valid=0.
- WIDTH=4, LSB_FIRST=0: accept 4'b1101.
  - Expect sout=1,1,0,1, with sout_last on the 4th bit.
- Back-to-back: 4'b1101, then 4'b0010 presented during sout_last.
  - Expect 8 contiguous valid bits 1,0,1,1,0,1,0,0.
  - Expect sout_last on bits 4 and 8, with no sout_valid gap.
- Hold-off: after accepting 4'b1101, assert load_valid with 4'b0110 on cycles 1-2 of the frame.
  - Expect load_ready=0 on those cycles and the stream unchanged at 1,0,1,1.
  - The 4'b0110 word is accepted only during sout_last.
- Reset mid-frame: accept 4'b1101, assert rst after 2 bits.
  - Expect sout=0, sout_valid=0 and busy=0 at the next edge, with no further bits.
  - A new accept of 4'b0011 yields 1,1,0,0.
- Idle/reset values: rst=1 for 2 cycles, then load_valid=0 for 5 cycles.
  - Expect sout=0, sout_valid=0, sout_last=0, busy=0 and load_ready=1 throughout.
